// File: rtl/smm_accum.sv
// smm_accum: lane-wise accumulator that sums K_TILES Strassen 2x2 products into one tile.
// Completed tiles go out through a valid/ready FIFO. Define SMM_ACC_SAT_EN for saturating lane adds; otherwise the adds wrap.
module smm_accum #(
  parameter int DATAWIDTH  = 128,
  parameter int BLOCKSIZE  = 32,
  parameter int K_TILES    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_in,
  input  logic [DATAWIDTH-1:0] C_in,
  output logic                 in_ready,
  output logic [DATAWIDTH-1:0] acc_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [7:0]           tile_cnt,
  output logic                 err
);
  localparam int NUM_LANES = DATAWIDTH / BLOCKSIZE;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [7:0] LAST = 8'(K_TILES - 1);

  typedef logic [NUM_LANES-1:0][BLOCKSIZE-1:0] tile_t;

  logic [2:1]    vld_pipe_q;
  tile_t         acc_q, acc_d, sum, c_lanes;
  logic [7:0]    tile_cnt_q, tile_cnt_d;
  tile_t         mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW:0]   occ;
  logic          err_q, err_d;
  logic          fold, first, last, push_req, push, pop, full;

  assign c_lanes = C_in;
  assign first   = (tile_cnt_q == 8'd0);

  // The first product of a tile ignores whatever is left in acc_q.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [BLOCKSIZE-1:0] base;
    assign base = first ? '0 : acc_q[l];
`ifdef SMM_ACC_SAT_EN
    logic signed [BLOCKSIZE:0] wide;
    assign wide = $signed({base[BLOCKSIZE-1], base}) +
                  $signed({c_lanes[l][BLOCKSIZE-1], c_lanes[l]});
    assign sum[l] = (wide[BLOCKSIZE] == wide[BLOCKSIZE-1]) ? wide[BLOCKSIZE-1:0] :
                    {wide[BLOCKSIZE], {(BLOCKSIZE-1){~wide[BLOCKSIZE]}}};
`else
    assign sum[l] = base + c_lanes[l];
`endif
  end

  always_comb begin
    fold     = vld_pipe_q[2];
    last     = (tile_cnt_q == LAST);
    push_req = fold && last;
    full     = (cnt_q == CW'(FIFO_DEPTH));
    pop      = out_valid && out_ready;
    // A pop on the same edge frees the slot, even when the FIFO is full.
    push     = push_req && (!full || pop);

    // Products still in the alignment pipe reserve a FIFO slot.
    occ      = {1'b0, cnt_q} + {{CW{1'b0}}, vld_pipe_q[1]} + {{CW{1'b0}}, vld_pipe_q[2]};
    in_ready = (occ < (CW+1)'(FIFO_DEPTH));

    acc_d      = acc_q;
    tile_cnt_d = tile_cnt_q;
    if (fold) begin
      if (last) begin
        tile_cnt_d = 8'd0;
      end else begin
        acc_d      = sum;
        tile_cnt_d = tile_cnt_q + 8'd1;
      end
    end

    cnt_d = cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    err_d = err_q | (load_in & ~in_ready) | (push_req & full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      acc_q      <= '0;
      tile_cnt_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      vld_pipe_q <= {vld_pipe_q[1], load_in};
      acc_q      <= acc_d;
      tile_cnt_q <= tile_cnt_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      if (push) begin
        mem_q[wptr_q] <= sum;
        wptr_q        <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
    end
  end

  assign acc_out   = mem_q[rptr_q];
  assign out_valid = (cnt_q != '0);
  assign tile_cnt  = tile_cnt_q;
  assign err       = err_q;
endmodule

// File: tb/tb_smm_accum.sv
// Bench for smm_accum: three instances (K_TILES = 1, 2 and 4) driven side by side.
// An event-level queue model checks every cycle; tables and hand sequences cover the corner cases.
module tb_smm_accum;
  localparam int DW = 128, DEPTH = 4, NI = 3;
  localparam int KT [NI] = '{1, 2, 4};
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst [NI], load [NI], ordy [NI], irdy [NI], ov [NI], er [NI];
  logic [DW-1:0] cin [NI], aout [NI], nprod [NI];
  logic [7:0]    tc [NI];

  smm_accum #(.K_TILES(1), .FIFO_DEPTH(DEPTH)) u0 (.clk(clk), .rst(rst[0]), .load_in(load[0]),
    .C_in(cin[0]), .in_ready(irdy[0]), .acc_out(aout[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .tile_cnt(tc[0]), .err(er[0]));
  smm_accum #(.K_TILES(2), .FIFO_DEPTH(DEPTH)) u1 (.clk(clk), .rst(rst[1]), .load_in(load[1]),
    .C_in(cin[1]), .in_ready(irdy[1]), .acc_out(aout[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .tile_cnt(tc[1]), .err(er[1]));
  smm_accum #(.K_TILES(4), .FIFO_DEPTH(DEPTH)) u2 (.clk(clk), .rst(rst[2]), .load_in(load[2]),
    .C_in(cin[2]), .in_ready(irdy[2]), .acc_out(aout[2]), .out_valid(ov[2]),
    .out_ready(ordy[2]), .tile_cnt(tc[2]), .err(er[2]));

  // Model: loads in flight, the open partial sum, the expected FIFO contents, sticky error.
  logic          in1 [NI], in2 [NI], merr [NI];
  logic [DW-1:0] p1 [NI], p2 [NI], macc [NI];
  logic [DW-1:0] mq [NI][8];
  int            mk [NI], mhead [NI], mcnt [NI];
  int            n_cmp = 0, n_bad = 0;

  function automatic logic [31:0] ladd(input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
`ifdef SMM_ACC_SAT_EN
    if (s > SMAX) s = SMAX;
    else if (s < SMIN) s = SMIN;
`endif
    return s[31:0];
  endfunction

  function automatic logic [DW-1:0] tadd(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] r;
    for (int l = 0; l < 4; l++) r[l*32 +: 32] = ladd(a[l*32 +: 32], b[l*32 +: 32]);
    return r;
  endfunction

  function automatic logic [DW-1:0] rnd_tile();
    logic [DW-1:0] r;
    for (int l = 0; l < 4; l++) begin
      case ($urandom_range(0, 5))
        0:       r[l*32 +: 32] = 32'h7FFFFFFF;
        1:       r[l*32 +: 32] = 32'h80000000;
        2:       r[l*32 +: 32] = 32'hFFFFFFFF;
        default: r[l*32 +: 32] = $urandom();
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_clear(input int i);
    in1[i] = 0; in2[i] = 0; merr[i] = 0; p1[i] = '0; p2[i] = '0; macc[i] = '0;
    mk[i] = 0; mhead[i] = 0; mcnt[i] = 0;
  endtask

  // One clock edge as seen by the model; inputs are the values held across the edge.
  task automatic model_edge(input int i);
    bit pop, mir;
    logic [DW-1:0] s;
    if (rst[i]) begin
      model_clear(i);
    end else begin
      mir = (mcnt[i] + int'(in1[i]) + int'(in2[i])) < DEPTH;
      if (load[i] && !mir) merr[i] = 1;
      pop = (mcnt[i] > 0) && ordy[i];
      if (in2[i]) begin
        s = tadd((mk[i] == 0) ? {DW{1'b0}} : macc[i], p2[i]);
        if (mk[i] == KT[i] - 1) begin
          mk[i] = 0;
          if (mcnt[i] - int'(pop) < DEPTH) begin
            mq[i][(mhead[i] + mcnt[i]) % 8] = s;
            mcnt[i]++;
          end else merr[i] = 1;
        end else begin
          macc[i] = s;
          mk[i]++;
        end
      end
      if (pop) begin
        mhead[i] = (mhead[i] + 1) % 8;
        mcnt[i]--;
      end
      in2[i] = in1[i]; p2[i] = p1[i];
      in1[i] = load[i]; p1[i] = nprod[i];
    end
  endtask

  task automatic check_inst(input int i);
    chk($sformatf("u%0d.out_valid", i), ov[i], mcnt[i] > 0);
    if (mcnt[i] > 0) chk($sformatf("u%0d.acc_out", i), aout[i], mq[i][mhead[i]]);
    chk($sformatf("u%0d.tile_cnt", i), tc[i], mk[i]);
    chk($sformatf("u%0d.err", i), er[i], merr[i]);
    chk($sformatf("u%0d.in_ready", i), irdy[i], (mcnt[i] + int'(in1[i]) + int'(in2[i])) < DEPTH);
  endtask

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < NI; i++) model_edge(i);
    #1;
    for (int i = 0; i < NI; i++) begin
      cin[i] = in2[i] ? p2[i] : {$urandom(), $urandom(), $urandom(), $urandom()};
      check_inst(i);
    end
  endtask

  task automatic go(input int i, input logic l, input logic [DW-1:0] p);
    load[i] = l; nprod[i] = p;
    step();
    load[i] = 1'b0;
  endtask

  typedef struct { logic [DW-1:0] p0, p1, exp; } vec_t;
  vec_t tbl [4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] bp [6];
    logic [DW-1:0] q [4];
    logic [DW-1:0] expsum;
    int w, accn, k;

    tbl[0] = '{{32'd1, 32'd2, 32'd3, 32'd4}, {32'd10, 32'd20, 32'd30, 32'd40},
               {32'd11, 32'd22, 32'd33, 32'd44}};
    tbl[1].p0 = {32'h7FFFFFFF, 96'd0}; tbl[1].p1 = {32'd1, 96'd0};
    tbl[2].p0 = {32'h80000000, 96'd0}; tbl[2].p1 = {32'hFFFFFFFF, 96'd0};
`ifdef SMM_ACC_SAT_EN
    tbl[1].exp = {32'h7FFFFFFF, 96'd0}; tbl[2].exp = {32'h80000000, 96'd0};
`else
    tbl[1].exp = {32'h80000000, 96'd0}; tbl[2].exp = {32'h7FFFFFFF, 96'd0};
`endif
    tbl[3] = '{{-32'sd5, 32'sd100, -32'sd1, 32'sd7}, {32'sd3, -32'sd200, -32'sd1, 32'sd0},
               {-32'sd2, -32'sd100, -32'sd2, 32'sd7}};

    for (int i = 0; i < NI; i++) begin
      rst[i] = 1; load[i] = 0; ordy[i] = 1; cin[i] = '0; nprod[i] = '0;
      model_clear(i);
    end
    step(); step();
    for (int i = 0; i < NI; i++) rst[i] = 0;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst%0d.acc_out", i), aout[i], '0);
      chk($sformatf("rst%0d.out_valid", i), ov[i], 0);
      chk($sformatf("rst%0d.tile_cnt", i), tc[i], 0);
      chk($sformatf("rst%0d.err", i), er[i], 0);
      chk($sformatf("rst%0d.in_ready", i), irdy[i], 1);
    end

    // Two-product tiles, K_TILES = 2.
    for (int r = 0; r < 4; r++) begin
      go(1, 1, tbl[r].p0);
      go(1, 1, tbl[r].p1);
      w = 0;
      while (!ov[1] && w < 8) begin step(); w++; end
      chk($sformatf("tbl%0d.valid", r), ov[1], 1);
      chk($sformatf("tbl%0d.acc", r), aout[1], tbl[r].exp);
      chk($sformatf("tbl%0d.tile_cnt", r), tc[1], 0);
      step();
      chk($sformatf("tbl%0d.one_cycle", r), ov[1], 0);
    end

    // Completion latency with K_TILES = 1.
    go(0, 1, {32'd5, 32'd6, 32'd7, 32'd8});
    chk("lat.e0", ov[0], 0);
    step(); chk("lat.e1", ov[0], 0);
    step(); chk("lat.e2", ov[0], 1);
    chk("lat.acc", aout[0], {32'd5, 32'd6, 32'd7, 32'd8});
    step(); chk("lat.e3", ov[0], 0);

    // Back-pressure: consumer stalled, issue whenever allowed.
    ordy[0] = 0; accn = 0;
    for (int c = 0; c < 12; c++) begin
      logic [DW-1:0] p;
      logic l;
      p = rnd_tile();
      l = irdy[0] && (accn < 5);
      if (l) begin bp[accn] = p; accn++; end
      go(0, l, p);
    end
    chk("bp.accepted", accn, 4);
    chk("bp.in_ready", irdy[0], 0);
    chk("bp.err", er[0], 0);
    chk("bp.valid", ov[0], 1);

    // Forced load while stalled: flagged and its tile dropped.
    bp[4] = rnd_tile(); bp[5] = '0;
    go(0, 1, bp[4]);
    step(); step(); step();
    chk("perr.err", er[0], 1);
    chk("perr.head", aout[0], bp[0]);
    ordy[0] = 1; k = 0;
    while (ov[0] && k < 6) begin
      chk($sformatf("drain%0d", k), aout[0], bp[k]);
      k++;
      step();
    end
    chk("drain.count", k, 4);
    step(); step();
    chk("perr.sticky", er[0], 1);
    rst[0] = 1; step(); rst[0] = 0;
    chk("perr.cleared", er[0], 0);

    // Reset while partially accumulated and with a load in flight, K_TILES = 4.
    go(2, 1, rnd_tile());
    go(2, 1, rnd_tile());
    step(); step();
    chk("mid.tile_cnt2", tc[2], 2);
    go(2, 1, rnd_tile());
    rst[2] = 1; step(); rst[2] = 0;
    chk("mid.tile_cnt", tc[2], 0);
    chk("mid.valid", ov[2], 0);
    chk("mid.in_ready", irdy[2], 1);
    for (int j = 0; j < 4; j++) begin q[j] = rnd_tile(); go(2, 1, q[j]); end
    expsum = tadd(tadd(tadd(q[0], q[1]), q[2]), q[3]);
    w = 0;
    while (!ov[2] && w < 8) begin step(); w++; end
    chk("mid.valid_after", ov[2], 1);
    chk("mid.sum", aout[2], expsum);
    step();

    // Randomised traffic on all instances against the model.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NI; i++) begin
        load[i]  = irdy[i] && ($urandom_range(0, 3) != 0);
        nprod[i] = rnd_tile();
        ordy[i]  = ($urandom_range(0, 2) != 0);
      end
      step();
    end
    for (int i = 0; i < NI; i++) begin load[i] = 0; ordy[i] = 1; end
    for (int c = 0; c < 12; c++) step();
    for (int i = 0; i < NI; i++) chk($sformatf("end%0d.empty", i), ov[i], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/smm_accum.md
# smm_accum

Downstream accumulation stage for the 2x2 Strassen block multiplier. It consumes the registered packed 2x2 product word and tracks which cycles carry valid products by delaying the multiplier's `load` pulse. It sums `K_TILES` consecutive products lane by lane into one output tile and hands each completed tile to the next stage through a small output FIFO with valid/ready. It applies back-pressure to the tile issuer through `in_ready`.

## Interface
Parameters:
- `DATAWIDTH`, 128: packed 2x2 tile width; four lanes.
- `BLOCKSIZE`, 32: lane width; signed two's complement.
- `K_TILES`, 4: products summed per output tile; range 1..255.
- `FIFO_DEPTH`, 4: output FIFO entries; power of two, at least 2.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `load_in` in 1: the same `load` pulse driven into the multiplier.
- `C_in` in DATAWIDTH: multiplier `C_out`. Lanes: [127:96]=C00, [95:64]=C01, [63:32]=C10, [31:0]=C11.
- `in_ready` out 1: the issuer may assert `load_in` only while this is high.
- `acc_out` out DATAWIDTH: FIFO head tile, same lane order as `C_in`.
- `out_valid` out 1: FIFO is non-empty.
- `out_ready` in 1: the consumer accepts the head tile.
- `tile_cnt` out 8: number of products already folded into the open accumulation.
- `err` out 1: sticky protocol error flag.

## Operation
- **Alignment.** Two-stage shift register `d1 <= load_in`, `d2 <= d1`. When `d2` is high, `C_in` holds the product of the load issued two edges earlier.
- **Accumulation.** On an edge with `d2` high:
  - Per lane, `sum = (tile_cnt==0 ? 0 : acc) + C_in`.
  - If `tile_cnt == K_TILES-1`: push `sum` into the FIFO and set `tile_cnt <= 0`.
  - Otherwise: `acc <= sum` and `tile_cnt <= tile_cnt + 1`.
- **Lane arithmetic.** Each lane is BLOCKSIZE-bit signed and lanes are independent; no carry crosses lanes. Overflow handling is set by the configuration macro.
- **Output FIFO.**
  - `acc_out` is the head entry, read from registered storage.
  - Pop occurs when `out_valid && out_ready`.
  - Push and pop on the same edge are both performed; the count is unchanged. This includes the full case, where the pop frees the slot.
- **Flow control.** `in_ready = (fifo_count + d1 + d2) < FIFO_DEPTH`, combinational. This is conservative, so no completion can ever find the FIFO full.
- **Errors.** `err` is set, and stays set until reset, on either event:
  - `load_in` asserted while `in_ready` is low. The load is still tracked and accumulated.
  - A push attempted while the FIFO is full and not popping. The tile is dropped.
- **Reset.** Clears `d1`, `d2`, `acc`, `tile_cnt`, FIFO pointers and count, and `err`. In-flight products are discarded; a product arriving after reset is ignored because `d2=0`.
- **Reset values.**
  - `acc_out` = 0 (storage cleared).
  - `out_valid` = 0, `tile_cnt` = 0, `err` = 0.
  - `in_ready` = 1.

## Timing
- `load_in` high before edge t. The multiplier captures operands at edge t, and its `C_out` is valid after edge t+1. This block folds the product at edge t+2.
- Completion latency, from the last tile's `load_in` edge to `out_valid`: 3 edges, i.e. `out_valid` high after edge t+2.
- Throughput: one product per cycle. With `K_TILES`=1 and `out_ready` held high, one tile per cycle.
- `in_ready` drops in the same cycle its condition becomes true; no registered slack.
- `tile_cnt` updates at the fold edge.

## Configuration
- `SMM_ACC_SAT_EN` defined: each lane add saturates to [-2^(BLOCKSIZE-1), 2^(BLOCKSIZE-1)-1], evaluated per add.
- Not defined: each lane add wraps modulo 2^BLOCKSIZE.
- No other behaviour differs between the two builds.

## Test plan
- **Basic sum.** `K_TILES`=2. Products {1,2,3,4} then {10,20,30,40} on consecutive folds, `out_ready`=1 -> `acc_out`={11,22,33,44} with `out_valid` for one cycle, and `tile_cnt` back to 0.
- **Latency.** `K_TILES`=1, single `load_in` at edge 0, `C_in`={5,6,7,8} at edge 2 -> `out_valid` high after edge 2 with {5,6,7,8}; no push on any other edge.
- **Overflow.** `K_TILES`=2, C00 products 0x7FFFFFFF then 1 -> C00=0x7FFFFFFF with `SMM_ACC_SAT_EN`, 0x80000000 without. Products 0x80000000 then -1 -> 0x80000000 with saturation, 0x7FFFFFFF without.
- **Back-pressure.** `K_TILES`=1, `FIFO_DEPTH`=4, `out_ready`=0, loads issued whenever `in_ready` is high -> exactly 4 loads accepted, `in_ready` low after the 4th, FIFO holds 4 tiles in order, `err`=0. Raising `out_ready` drains them in order.
- **Protocol error.** Same setup; force a 5th `load_in` while `in_ready`=0 -> `err`=1 and the 5th tile is dropped. `err` stays 1 until `rst`.
- **Reset mid-operation.** `K_TILES`=4, two products folded, `rst` pulsed one cycle while a load is in flight -> `tile_cnt`=0, `out_valid`=0, `in_ready`=1. The next 4 products produce a tile equal to their sum only.
